// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with rename tracking.
// Holds committed values plus a busy bit and producing ROB tag per
// register. Accepts two in-order commits and one rename per cycle and
// a flush. It serves two operand lookups with commit and ROB forwarding.
// It also keeps a registered count of busy registers.
module rename_regfile #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int ROB_BIT = 4,
   localparam int IDX    = $clog2(NREG),
   localparam int CNT    = IDX + 1
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush_in,
   input  logic                cm0_valid,
   input  logic [IDX-1:0]      cm0_rd,
   input  logic [XLEN-1:0]     cm0_data,
   input  logic [ROB_BIT-1:0]  cm0_tag,
   input  logic                cm1_valid,
   input  logic [IDX-1:0]      cm1_rd,
   input  logic [XLEN-1:0]     cm1_data,
   input  logic [ROB_BIT-1:0]  cm1_tag,
   input  logic                is_valid,
   input  logic [IDX-1:0]      is_rd,
   input  logic [ROB_BIT-1:0]  is_tag,
   input  logic [IDX-1:0]      src1_id,
   input  logic [IDX-1:0]      src2_id,
   output logic [XLEN-1:0]     src1_val,
   output logic [XLEN-1:0]     src2_val,
   output logic                src1_busy,
   output logic                src2_busy,
   output logic [ROB_BIT-1:0]  src1_tag,
   output logic [ROB_BIT-1:0]  src2_tag,
   output logic [ROB_BIT-1:0]  rob_q1_tag,
   output logic [ROB_BIT-1:0]  rob_q2_tag,
   input  logic                rob_q1_ready,
   input  logic                rob_q2_ready,
   input  logic [XLEN-1:0]     rob_q1_value,
   input  logic [XLEN-1:0]     rob_q2_value,
   output logic [CNT-1:0]      busy_count,
   output logic                all_clean
);

   // Architectural state
   logic [XLEN-1:0]    r_val [NREG];
   logic [NREG-1:0]    r_busy;
   logic [ROB_BIT-1:0] r_tag [NREG];
   logic [CNT-1:0]     r_busy_count;

   // Next-state values computed per register
   logic [XLEN-1:0]    w_val_next [NREG];
   logic [NREG-1:0]    w_busy_next;
   logic [ROB_BIT-1:0] w_tag_next [NREG];
   logic [CNT-1:0]     w_count_next;

   // Per-register update rules: the younger commit port overrides the
   // older one on the value. A rename overrides a tag-matching commit
   // clear. A flush drops every pending rename, including this cycle's.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign w_val_next[gi]  = '0;
         assign w_busy_next[gi] = 1'b0;
         assign w_tag_next[gi]  = '0;
      end else begin : g_arch
         logic w_cm0_hit;
         logic w_cm1_hit;
         logic w_is_hit;
         logic w_clear;

         assign w_cm0_hit = cm0_valid && (cm0_rd == IDX'(gi));
         assign w_cm1_hit = cm1_valid && (cm1_rd == IDX'(gi));
         assign w_is_hit  = is_valid && (is_rd == IDX'(gi)) && !flush_in;
         assign w_clear   = (w_cm0_hit && (cm0_tag == r_tag[gi])) ||
                            (w_cm1_hit && (cm1_tag == r_tag[gi]));

         assign w_val_next[gi]  = w_cm1_hit ? cm1_data :
                                  w_cm0_hit ? cm0_data : r_val[gi];
         assign w_busy_next[gi] = flush_in ? 1'b0 :
                                  w_is_hit ? 1'b1 :
                                  w_clear  ? 1'b0 : r_busy[gi];
         assign w_tag_next[gi]  = flush_in ? '0 :
                                  w_is_hit ? is_tag :
                                  w_clear  ? '0 : r_tag[gi];
      end
   end

   // Population count of the next busy vector, so the counter can never drift
   always_comb begin
      w_count_next = '0;
      for (int i = 0; i < NREG; i++) begin
         w_count_next = w_count_next + CNT'(w_busy_next[i]);
      end
   end

   // State registers; rdy_in low freezes everything
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            r_val[i] <= '0;
            r_tag[i] <= '0;
         end
         r_busy       <= '0;
         r_busy_count <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < NREG; i++) begin
            r_val[i] <= w_val_next[i];
            r_tag[i] <= w_tag_next[i];
         end
         r_busy       <= w_busy_next;
         r_busy_count <= w_count_next;
      end
   end

   // Lookup port inputs gathered into arrays
   logic [IDX-1:0]     w_sid     [2];
   logic               w_rob_rdy [2];
   logic [XLEN-1:0]    w_rob_val [2];
   logic [XLEN-1:0]    w_src_val  [2];
   logic               w_src_busy [2];
   logic [ROB_BIT-1:0] w_src_tag  [2];
   logic [ROB_BIT-1:0] w_raw_tag  [2];

   assign w_sid[0]     = src1_id;
   assign w_sid[1]     = src2_id;
   assign w_rob_rdy[0] = rob_q1_ready;
   assign w_rob_rdy[1] = rob_q2_ready;
   assign w_rob_val[0] = rob_q1_value;
   assign w_rob_val[1] = rob_q2_value;

   // Operand lookup: the younger commit is checked first, then the older
   // one, then the ROB. This cycle's rename is deliberately not visible.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_raw_tag[p]  = r_tag[w_sid[p]];
         w_src_val[p]  = '0;
         w_src_busy[p] = 1'b0;
         w_src_tag[p]  = '0;
         if (w_sid[p] != '0) begin
            if (!r_busy[w_sid[p]]) begin
               w_src_val[p] = r_val[w_sid[p]];
            end else if (cm1_valid && (cm1_rd == w_sid[p]) &&
                         (cm1_tag == r_tag[w_sid[p]])) begin
               w_src_val[p] = cm1_data;
            end else if (cm0_valid && (cm0_rd == w_sid[p]) &&
                         (cm0_tag == r_tag[w_sid[p]])) begin
               w_src_val[p] = cm0_data;
            end else if (w_rob_rdy[p]) begin
               w_src_val[p] = w_rob_val[p];
            end else begin
               w_src_busy[p] = 1'b1;
               w_src_tag[p]  = r_tag[w_sid[p]];
            end
         end
      end
   end

   assign src1_val   = w_src_val[0];
   assign src2_val   = w_src_val[1];
   assign src1_busy  = w_src_busy[0];
   assign src2_busy  = w_src_busy[1];
   assign src1_tag   = w_src_tag[0];
   assign src2_tag   = w_src_tag[1];
   assign rob_q1_tag = w_raw_tag[0];
   assign rob_q2_tag = w_raw_tag[1];

   assign busy_count = r_busy_count;
   assign all_clean  = (r_busy_count == '0);

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scenarios plus randomized traffic, compared
// against a sequential behavioural model of the register file.
module tb_rename_regfile;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RB   = 4;
   localparam int IDX  = 5;
   localparam int CNT  = 6;

   logic            clk_in = 1'b0;
   logic            rst_in, rdy_in, flush_in;
   logic            cm0_valid, cm1_valid, is_valid;
   logic [IDX-1:0]  cm0_rd, cm1_rd, is_rd, src1_id, src2_id;
   logic [XLEN-1:0] cm0_data, cm1_data, rob_q1_value, rob_q2_value;
   logic [RB-1:0]   cm0_tag, cm1_tag, is_tag;
   logic            rob_q1_ready, rob_q2_ready;
   logic [XLEN-1:0] src1_val, src2_val;
   logic            src1_busy, src2_busy;
   logic [RB-1:0]   src1_tag, src2_tag, rob_q1_tag, rob_q2_tag;
   logic [CNT-1:0]  busy_count;
   logic            all_clean;

   int n_checks = 0;
   int n_errors = 0;
   int n_cycle  = 0;

   // Reference model state
   logic [XLEN-1:0] m_val  [NREG];
   bit              m_busy [NREG];
   logic [RB-1:0]   m_tag  [NREG];

   always #5 clk_in = ~clk_in;

   rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_BIT(RB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .cm0_valid(cm0_valid), .cm0_rd(cm0_rd), .cm0_data(cm0_data), .cm0_tag(cm0_tag),
      .cm1_valid(cm1_valid), .cm1_rd(cm1_rd), .cm1_data(cm1_data), .cm1_tag(cm1_tag),
      .is_valid(is_valid), .is_rd(is_rd), .is_tag(is_tag),
      .src1_id(src1_id), .src2_id(src2_id),
      .src1_val(src1_val), .src2_val(src2_val),
      .src1_busy(src1_busy), .src2_busy(src2_busy),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
      .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
      .rob_q1_value(rob_q1_value), .rob_q2_value(rob_q2_value),
      .busy_count(busy_count), .all_clean(all_clean)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) begin
         m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
   endtask

   // Expected lookup result for one port, from the current model state
   task automatic exp_lookup(input logic [IDX-1:0] id, input logic rr, input logic [XLEN-1:0] rv,
                             output logic [XLEN-1:0] v, output logic b, output logic [RB-1:0] t);
      v = '0; b = 1'b0; t = '0;
      if (id != 0) begin
         if (!m_busy[id]) v = m_val[id];
         else if (cm1_valid && cm1_rd == id && cm1_tag == m_tag[id]) v = cm1_data;
         else if (cm0_valid && cm0_rd == id && cm0_tag == m_tag[id]) v = cm0_data;
         else if (rr) v = rv;
         else begin b = 1'b1; t = m_tag[id]; end
      end
   endtask

   task automatic check_lookups();
      logic [XLEN-1:0] v; logic b; logic [RB-1:0] t;
      exp_lookup(src1_id, rob_q1_ready, rob_q1_value, v, b, t);
      chk("src1_val", src1_val, v);
      chk("src1_busy", src1_busy, b);
      chk("src1_tag", src1_tag, t);
      chk("rob_q1_tag", rob_q1_tag, m_tag[src1_id]);
      exp_lookup(src2_id, rob_q2_ready, rob_q2_value, v, b, t);
      chk("src2_val", src2_val, v);
      chk("src2_busy", src2_busy, b);
      chk("src2_tag", src2_tag, t);
      chk("rob_q2_tag", rob_q2_tag, m_tag[src2_id]);
   endtask

   // One clock edge of model behaviour, applied as sequential steps
   task automatic model_update();
      logic [RB-1:0] old_tag [NREG];
      bit c0, c1;
      if (!rdy_in) return;
      for (int i = 0; i < NREG; i++) old_tag[i] = m_tag[i];
      c0 = cm0_valid && cm0_rd != 0 && cm0_tag == old_tag[cm0_rd];
      c1 = cm1_valid && cm1_rd != 0 && cm1_tag == old_tag[cm1_rd];
      if (cm0_valid && cm0_rd != 0) m_val[cm0_rd] = cm0_data;
      if (cm1_valid && cm1_rd != 0) m_val[cm1_rd] = cm1_data;
      if (c0) begin m_busy[cm0_rd] = 0; m_tag[cm0_rd] = '0; end
      if (c1) begin m_busy[cm1_rd] = 0; m_tag[cm1_rd] = '0; end
      if (is_valid && is_rd != 0) begin m_busy[is_rd] = 1; m_tag[is_rd] = is_tag; end
      if (flush_in) for (int i = 0; i < NREG; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_in = 1'b0;
      cm0_valid = 1'b0; cm0_rd = '0; cm0_data = '0; cm0_tag = '0;
      cm1_valid = 1'b0; cm1_rd = '0; cm1_data = '0; cm1_tag = '0;
      is_valid = 1'b0; is_rd = '0; is_tag = '0;
      src1_id = '0; src2_id = '0;
      rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_value = '0; rob_q2_value = '0;
   endtask

   // Inputs are set just after a negedge; check lookups, clock, check count
   task automatic cyc();
      #1;
      check_lookups();
      @(posedge clk_in);
      model_update();
      #1;
      chk("busy_count", busy_count, m_count());
      chk("all_clean", all_clean, m_count() == 0);
      n_cycle++;
      $display("cyc %0d rdy=%0b fl=%0b cm0=%0b/%0d/%0d cm1=%0b/%0d/%0d is=%0b/%0d/%0d cnt=%0d",
               n_cycle, rdy_in, flush_in, cm0_valid, cm0_rd, cm0_tag, cm1_valid, cm1_rd, cm1_tag,
               is_valid, is_rd, is_tag, busy_count);
      @(negedge clk_in);
   endtask

   task automatic issue(input int rd, input int tg);
      idle(); is_valid = 1'b1; is_rd = IDX'(rd); is_tag = RB'(tg); cyc();
   endtask

   task automatic rand_inputs();
      rdy_in    = ($urandom_range(0, 7) != 0);
      flush_in  = ($urandom_range(0, 24) == 0);
      cm0_valid = $urandom_range(0, 1);
      cm0_rd    = IDX'($urandom_range(0, 7));
      cm0_tag   = ($urandom_range(0, 2) != 0) ? m_tag[cm0_rd] : RB'($urandom);
      cm0_data  = $urandom;
      cm1_valid = $urandom_range(0, 1);
      cm1_rd    = IDX'($urandom_range(0, 7));
      cm1_tag   = ($urandom_range(0, 2) != 0) ? m_tag[cm1_rd] : RB'($urandom);
      cm1_data  = $urandom;
      is_valid  = $urandom_range(0, 1);
      is_rd     = IDX'($urandom_range(0, 7));
      is_tag    = RB'($urandom);
      src1_id   = IDX'($urandom_range(0, 8));
      src2_id   = IDX'($urandom_range(0, 8));
      rob_q1_ready = ($urandom_range(0, 3) == 0);
      rob_q2_ready = ($urandom_range(0, 3) == 0);
      rob_q1_value = $urandom;
      rob_q2_value = $urandom;
   endtask

   initial begin
      idle();
      rst_in = 1'b1;
      m_reset();
      @(negedge clk_in);
      @(negedge clk_in);
      // Reset state
      src1_id = 5'd5; src2_id = 5'd0;
      #1;
      chk("rst_count", busy_count, 0);
      chk("rst_clean", all_clean, 1);
      check_lookups();
      @(negedge clk_in);
      rst_in = 1'b0;

      // Issue x5 tag 3, then look it up with and without ROB data
      issue(5, 3);
      idle(); src1_id = 5'd5;
      #1;
      chk("x5_busy", src1_busy, 1);
      chk("x5_tag", src1_tag, 3);
      chk("x5_robq", rob_q1_tag, 3);
      rob_q1_ready = 1'b1; rob_q1_value = 32'hAB;
      #1;
      chk("x5_rob_val", src1_val, 32'hAB);
      chk("x5_rob_busy", src1_busy, 0);
      cyc();

      // Same-cycle commit forwarding on cm0
      idle(); src1_id = 5'd5;
      cm0_valid = 1'b1; cm0_rd = 5'd5; cm0_tag = 4'd3; cm0_data = 32'h11;
      #1;
      chk("x5_fwd_val", src1_val, 32'h11);
      chk("x5_fwd_busy", src1_busy, 0);
      cyc();
      chk("x5_cnt_after", busy_count, 0);
      idle(); src1_id = 5'd5;
      #1;
      chk("x5_committed", src1_val, 32'h11);
      cyc();

      // Dual commit to x7, younger port wins
      issue(7, 4);
      idle();
      cm0_valid = 1'b1; cm0_rd = 5'd7; cm0_tag = 4'd2; cm0_data = 32'h1;
      cm1_valid = 1'b1; cm1_rd = 5'd7; cm1_tag = 4'd4; cm1_data = 32'h2;
      cyc();
      idle(); src2_id = 5'd7;
      #1;
      chk("x7_val", src2_val, 32'h2);
      chk("x7_busy", src2_busy, 0);
      cyc();
      // Stale commit: value written, rename stays pending
      issue(7, 4);
      idle(); cm0_valid = 1'b1; cm0_rd = 5'd7; cm0_tag = 4'd9; cm0_data = 32'h33;
      cyc();
      idle(); src2_id = 5'd7;
      #1;
      chk("x7_stale_busy", src2_busy, 1);
      chk("x7_stale_tag", src2_tag, 4);
      cyc();

      // Commit and re-issue of x9 in one cycle
      issue(9, 6);
      idle();
      cm0_valid = 1'b1; cm0_rd = 5'd9; cm0_tag = 4'd6; cm0_data = 32'h99;
      is_valid = 1'b1; is_rd = 5'd9; is_tag = 4'd8;
      cyc();
      idle(); src1_id = 5'd9;
      #1;
      chk("x9_busy", src1_busy, 1);
      chk("x9_tag", src1_tag, 8);
      cyc();

      // Four busy registers, then flush with a commit and an issue
      issue(3, 1);
      issue(11, 5);
      chk("pre_flush_cnt", busy_count, 4);
      idle(); flush_in = 1'b1;
      cm0_valid = 1'b1; cm0_rd = 5'd3; cm0_tag = 4'd0; cm0_data = 32'h55;
      is_valid = 1'b1; is_rd = 5'd4; is_tag = 4'd2;
      cyc();
      chk("flush_cnt", busy_count, 0);
      chk("flush_clean", all_clean, 1);
      idle(); src1_id = 5'd3; src2_id = 5'd4;
      #1;
      chk("x3_val", src1_val, 32'h55);
      chk("x4_busy", src2_busy, 0);
      cyc();
      idle(); src1_id = 5'd7; src2_id = 5'd9;
      #1;
      chk("x7_val_flush", src1_val, 32'h33);
      chk("x9_val_flush", src2_val, 32'h99);
      cyc();

      // rdy_in low holds state
      idle(); rdy_in = 1'b0; is_valid = 1'b1; is_rd = 5'd12; is_tag = 4'd3;
      cyc();
      idle(); src1_id = 5'd12;
      #1;
      chk("hold_busy", src1_busy, 0);
      chk("hold_cnt", busy_count, 0);
      cyc();

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         rand_inputs();
         cyc();
      end

      // Asynchronous reset mid-run with a busy register
      issue(5, 7);
      issue(6, 2);
      idle(); src1_id = 5'd5;
      #2;
      rst_in = 1'b1;
      #1;
      chk("arst_cnt", busy_count, 0);
      chk("arst_clean", all_clean, 1);
      chk("arst_val", src1_val, 0);
      chk("arst_busy", src1_busy, 0);
      m_reset();
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 150; i++) begin
         rand_inputs();
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
